// File: rtl/mem_unit.sv
// Memory execution unit behind the load/store queue: one access in flight, fixed LATENCY to data.
// Loads broadcast tag+data on the CDB once granted (stalls in WAIT_BC); stores pulse storeDone.
module mem_unit #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        require,
  output logic        requireAC,
  input  logic        opIn,
  input  logic [31:0] dataIn,
  input  logic [31:0] stData,
  input  logic [4:0]  destLabel,
  output logic        BCreq,
  input  logic        BCgrant,
  output logic        BCEN,
  output logic [4:0]  BClabel,
  output logic [31:0] BCdata,
  output logic        storeDone,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_BC, BCAST} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                op_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         st_q;
  logic [4:0]          tag_q;
  logic [31:0]         res_q;
  logic                bcreq_q;
  logic                bcen_q;
  logic [4:0]          bclabel_q;
  logic [31:0]         bcdata_q;
  logic                done_q;
  logic [31:0]         mem_q [DEPTH];

  // Word index only; byte offset and high bits are dropped so addresses alias.
  logic [ADDR_W-1:0]   idx_d;
  logic                unused_addr_bits;
  assign idx_d            = dataIn[ADDR_W+1:2];
  assign unused_addr_bits = ^{dataIn[31:ADDR_W+2], dataIn[1:0]};

  assign requireAC = nRST && (state_q == IDLE) && require;
  assign busy      = (state_q != IDLE);
  assign BCreq     = bcreq_q;
  assign BCEN      = bcen_q;
  assign BClabel   = bclabel_q;
  assign BCdata    = bcdata_q;
  assign storeDone = done_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      idx_q     <= '0;
      st_q      <= '0;
      tag_q     <= '0;
      res_q     <= '0;
      bcreq_q   <= 1'b0;
      bcen_q    <= 1'b0;
      bclabel_q <= '0;
      bcdata_q  <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      bcen_q    <= 1'b0;
      bclabel_q <= '0;
      bcdata_q  <= '0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (require) begin
            state_q <= ACCESS;
            cnt_q   <= 4'(LATENCY - 1);
            op_q    <= opIn;
            idx_q   <= idx_d;
            st_q    <= stData;
            tag_q   <= destLabel;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (op_q) begin
              mem_q[idx_q] <= st_q;
              done_q       <= 1'b1;
              state_q      <= IDLE;
            end else if (tag_q != 5'd0) begin
              res_q   <= mem_q[idx_q];
              bcreq_q <= 1'b1;
              state_q <= WAIT_BC;
            end else begin
              // Tag 0 means nobody is waiting for the result.
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WAIT_BC: begin
          if (BCgrant) begin
            bcreq_q   <= 1'b0;
            bcen_q    <= 1'b1;
            bclabel_q <= tag_q;
            bcdata_q  <= res_q;
            state_q   <= BCAST;
          end
        end
        BCAST:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: expected broadcasts/store completions are queued at issue
// and popped by an independent negedge monitor; timing points are checked inline.
module tb_mem_unit;
  logic        clk = 1'b0;
  logic        nRST, require, opIn, BCgrant;
  logic [31:0] dataIn, stData;
  logic [4:0]  destLabel;
  logic        requireAC, BCreq, BCEN, storeDone, busy;
  logic [4:0]  BClabel;
  logic [31:0] BCdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [4:0] tag; logic [31:0] data;} bc_t;
  bc_t bq[$];
  int  sq[$];

  mem_unit #(.DEPTH(64), .ADDR_W(6), .LATENCY(2)) dut (
    .clk(clk), .nRST(nRST), .require(require), .requireAC(requireAC),
    .opIn(opIn), .dataIn(dataIn), .stData(stData), .destLabel(destLabel),
    .BCreq(BCreq), .BCgrant(BCgrant), .BCEN(BCEN), .BClabel(BClabel),
    .BCdata(BCdata), .storeDone(storeDone), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a head at a negedge, hold until accepted, drop require after the accept edge.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] t);
    int n = 0;
    @(negedge clk);
    require = 1'b1; opIn = op; dataIn = a; stData = sd; destLabel = t;
    #1;
    while (!requireAC && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_timeout", requireAC, 1);
    @(posedge clk); #1 require = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    bc_t e;
    if (nRST === 1'b1) begin
      if (BCEN) begin
        if (bq.size() == 0) chk("bcast_unexpected", BCEN, 0);
        else begin
          e = bq.pop_front();
          chk("bc_label", BClabel, e.tag);
          chk("bc_data", BCdata, e.data);
        end
      end
      if (storeDone) begin
        if (sq.size() == 0) chk("done_unexpected", storeDone, 0);
        else begin
          void'(sq.pop_front());
          chk("store_done", storeDone, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; require = 1'b0; opIn = 1'b0; dataIn = '0; stData = '0;
    destLabel = '0; BCgrant = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {requireAC, BCreq, BCEN, BClabel, BCdata, storeDone, busy}, 0);
    nRST = 1'b1;
    @(negedge clk);

    // Store 0xDEADBEEF to word 4
    sq.push_back(4);
    issue(1'b1, 32'h10, 32'hDEADBEEF, 5'd3);
    @(negedge clk); chk("st_busy1", {busy, BCreq}, 2'b10);
    @(negedge clk); chk("st_busy2", {busy, BCreq}, 2'b10);
    @(negedge clk); chk("st_done", {busy, storeDone}, 2'b01);
    @(negedge clk); chk("st_done_pulse", storeDone, 0);

    // Load back, grant tied high
    bq.push_back('{tag: 5'd5, data: 32'hDEADBEEF});
    issue(1'b0, 32'h10, 32'h0, 5'd5);
    repeat (2) @(negedge clk);
    @(negedge clk); chk("ld_bcreq", {BCreq, BCEN}, 2'b10);
    @(negedge clk); chk("ld_bcen", {BCEN, BCreq, busy}, 3'b101);
    @(negedge clk); chk("ld_idle", {busy, BCEN}, 0);

    // Delayed grant with the alias store already pending at the head
    BCgrant = 1'b0;
    bq.push_back('{tag: 5'd7, data: 32'hDEADBEEF});
    issue(1'b0, 32'h10, 32'h0, 5'd7);
    require = 1'b1; opIn = 1'b1; dataIn = 32'h13; stData = 32'h55; destLabel = 5'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("wait_hold", {BCreq, BCEN, requireAC}, 3'b100);
    end
    sq.push_back(4);
    BCgrant = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("accept_after_bcast", requireAC, 1);
    @(posedge clk); #1 require = 1'b0;
    repeat (3) @(negedge clk);

    // Aliased load: 0x110 and 0x13 both map to word 4
    bq.push_back('{tag: 5'd9, data: 32'h55});
    issue(1'b0, 32'h110, 32'h0, 5'd9);
    repeat (6) @(negedge clk);

    // Reset in the middle of a store
    issue(1'b1, 32'h40, 32'hCAFEF00D, 5'd2);
    @(negedge clk);
    nRST = 1'b0;
    #1 chk("reset_mid_outputs", {requireAC, BCreq, BCEN, BClabel, BCdata, storeDone, busy}, 0);
    @(negedge clk);
    nRST = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_mid_idle", busy, 0);

    // Tag-0 load: busy for LATENCY cycles, no CDB activity
    issue(1'b0, 32'h40, 32'h0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("nt_busy", {busy, BCreq}, 2'b10);
    end
    @(negedge clk); chk("nt_idle", {busy, BCreq, BCEN}, 0);
    require = 1'b1; opIn = 1'b0; dataIn = 32'h40; stData = '0; destLabel = 5'd11;
    bq.push_back('{tag: 5'd11, data: 32'h0});
    #1 chk("nt_accept", requireAC, 1);
    @(posedge clk); #1 require = 1'b0;
    repeat (5) @(negedge clk);

    // Word 4 was cleared by the reset
    bq.push_back('{tag: 5'd12, data: 32'h0});
    issue(1'b0, 32'h10, 32'h0, 5'd12);
    repeat (6) @(negedge clk);

    chk("bq_drained", bq.size(), 0);
    chk("sq_drained", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
